// File: rtl/joypad_pkg.sv
// Shared definitions for the serial joypad port: button indices, widths, FSM encoding
// and the opposing-direction mask applied to the debounced buttons before loading.
package joypad_pkg;

  localparam int unsigned JOY_WIDTH = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic FILL_DEFAULT = 1'b1;

  typedef enum logic {
    JP_LOAD  = 1'b0,
    JP_SHIFT = 1'b1
  } jp_state_e;

  // Physically impossible pad states are reported as neither direction pressed.
  function automatic logic [JOY_WIDTH-1:0] mask_opposing(input logic [JOY_WIDTH-1:0] db,
                                                         input logic               en);
    logic [JOY_WIDTH-1:0] m;
    m = db;
    if (en && db[BTN_UP] && db[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end
    if (en && db[BTN_LEFT] && db[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/joypad_debounce.sv
// Single-bit debouncer: output follows input only after it has differed for
// DEBOUNCE_CYCLES consecutive clocks. DEBOUNCE_CYCLES of zero passes input straight through.
module joypad_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic CLK,
  input  logic RES,
  input  logic din,
  output logic dout
);

  if (DEBOUNCE_CYCLES == 16'd0) begin : g_bypass
    assign dout = din;
  end else begin : g_filter
    localparam int unsigned CW = $clog2(32'(DEBOUNCE_CYCLES) + 32'd1);
    localparam logic [CW-1:0] CntMax = CW'(32'(DEBOUNCE_CYCLES) - 32'd1);

    logic [CW-1:0] r_cnt;
    logic          r_db;

    always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (din == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_db  <= din;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign dout = r_db;
  end

endmodule

// File: rtl/joypad_port.sv
// Controller-side 4021-style responder: latches debounced buttons while strobe is high and
// shifts one button onto DOUT for every completed CPU read pulse.
module joypad_port
  import joypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        FILL_VALUE      = FILL_DEFAULT,
  parameter logic        BLOCK_OPPOSING  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 STROBE,
  input  logic                 OE_N,
  input  logic [JOY_WIDTH-1:0] BTN,
  output logic                 DOUT,
  output logic [3:0]           BIT_IDX
);

  logic [SYNC_STAGES-1:0]                r_strobe_sync;
  logic [SYNC_STAGES-1:0]                r_oe_n_sync;
  logic [SYNC_STAGES-1:0][JOY_WIDTH-1:0] r_btn_sync;
  logic                                  r_oe_n_d;

  logic                 w_s_strobe;
  logic                 w_s_oe_n;
  logic [JOY_WIDTH-1:0] w_s_btn;
  logic                 w_rd_done;
  logic [JOY_WIDTH-1:0] w_db;
  logic [JOY_WIDTH-1:0] w_load_val;

  // Chains reset to the idle bus state so reset release never looks like an edge.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_strobe_sync <= '0;
      r_oe_n_sync   <= '1;
      r_btn_sync    <= '0;
      r_oe_n_d      <= 1'b1;
    end else begin
      r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-2:0], STROBE};
      r_oe_n_sync   <= {r_oe_n_sync[SYNC_STAGES-2:0], OE_N};
      r_btn_sync    <= {r_btn_sync[SYNC_STAGES-2:0], BTN};
      r_oe_n_d      <= w_s_oe_n;
    end
  end

  assign w_s_strobe = r_strobe_sync[SYNC_STAGES-1];
  assign w_s_oe_n   = r_oe_n_sync[SYNC_STAGES-1];
  assign w_s_btn    = r_btn_sync[SYNC_STAGES-1];
  assign w_rd_done  = w_s_oe_n & ~r_oe_n_d;

  for (genvar i = 0; i < JOY_WIDTH; i++) begin : g_db
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK (CLK),
      .RES (RES),
      .din (w_s_btn[i]),
      .dout(w_db[i])
    );
  end

  assign w_load_val = mask_opposing(w_db, BLOCK_OPPOSING);

  jp_state_e            r_state;
  logic [JOY_WIDTH-1:0] r_sr;
  logic [3:0]           r_bit_idx;

  // A read completing in the same cycle strobe is seen high is swallowed by the load.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_state   <= JP_SHIFT;
      r_sr      <= '0;
      r_bit_idx <= 4'd0;
    end else begin
      unique case (r_state)
        JP_LOAD: begin
          if (w_s_strobe) begin
            r_sr      <= w_load_val;
            r_bit_idx <= 4'd0;
          end else begin
            r_state <= JP_SHIFT;
            if (w_rd_done) begin
              r_sr <= {FILL_VALUE, r_sr[JOY_WIDTH-1:1]};
              if (r_bit_idx != 4'd8) r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
        end
        JP_SHIFT: begin
          if (w_s_strobe) begin
            r_state   <= JP_LOAD;
            r_sr      <= w_load_val;
            r_bit_idx <= 4'd0;
          end else if (w_rd_done) begin
            r_sr <= {FILL_VALUE, r_sr[JOY_WIDTH-1:1]};
            if (r_bit_idx != 4'd8) r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        default: r_state <= JP_SHIFT;
      endcase
    end
  end

  assign DOUT    = r_sr[0];
  assign BIT_IDX = r_bit_idx;

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port: two instances (opposing-direction blocking on and off) driven
// in parallel, checked against a read-order model of the pad.
module tb_joypad_port;

  logic       clk;
  logic       res_n;
  logic       strobe;
  logic       oe_n;
  logic [7:0] btn;
  logic       dout_b, dout_nb;
  logic [3:0] idx_b, idx_nb;

  int n_pass  = 0;
  int n_total = 0;

  joypad_port #(
    .DEBOUNCE_CYCLES(16'd4),
    .SYNC_STAGES    (2),
    .FILL_VALUE     (1'b1),
    .BLOCK_OPPOSING (1'b1)
  ) dut (
    .CLK    (clk),
    .RES    (res_n),
    .STROBE (strobe),
    .OE_N   (oe_n),
    .BTN    (btn),
    .DOUT   (dout_b),
    .BIT_IDX(idx_b)
  );

  joypad_port #(
    .DEBOUNCE_CYCLES(16'd4),
    .SYNC_STAGES    (2),
    .FILL_VALUE     (1'b1),
    .BLOCK_OPPOSING (1'b0)
  ) dut_nb (
    .CLK    (clk),
    .RES    (res_n),
    .STROBE (strobe),
    .OE_N   (oe_n),
    .BTN    (btn),
    .DOUT   (dout_nb),
    .BIT_IDX(idx_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Value the pad should present: pressed buttons with impossible direction pairs cleared.
  function automatic logic [7:0] model_mask(input logic [7:0] b, input bit block);
    logic [7:0] m;
    m = b;
    if (block && b[4] && b[5]) m = m & 8'hCF;
    if (block && b[6] && b[7]) m = m & 8'h3F;
    return m;
  endfunction

  // k-th bit seen by the CPU after a latch: the buttons in order, then ones forever.
  function automatic logic [7:0] model_bit(input logic [7:0] m, input int k);
    return (k < 8) ? {7'd0, m[k]} : 8'd1;
  endfunction

  function automatic logic [7:0] model_idx(input int k);
    return (k > 8) ? 8'd8 : 8'(k);
  endfunction

  task automatic load(input logic [7:0] b);
    btn    = b;
    strobe = 1'b1;
    tick(10);
    strobe = 1'b0;
    tick(3);
  endtask

  task automatic do_read(input int k, input logic [7:0] mb, input logic [7:0] mn);
    check("read_blk", {7'd0, dout_b}, model_bit(mb, k));
    check("read_nb", {7'd0, dout_nb}, model_bit(mn, k));
    oe_n = 1'b0;
    tick(2);
    oe_n = 1'b1;
    tick(2);
    check("lat_idx", {4'd0, idx_b}, model_idx(k));
    tick(1);
    check("idx_blk", {4'd0, idx_b}, model_idx(k + 1));
    check("idx_nb", {4'd0, idx_nb}, model_idx(k + 1));
    check("next_blk", {7'd0, dout_b}, model_bit(mb, k + 1));
    check("next_nb", {7'd0, dout_nb}, model_bit(mn, k + 1));
    tick(1);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] mb;
    logic [7:0] mn;
    int         n;

    // Reset held with all buttons pressed and reads toggling.
    res_n  = 1'b0;
    strobe = 1'b0;
    oe_n   = 1'b1;
    btn    = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      oe_n = 1'b0;
      tick(2);
      check("rst_dout", {7'd0, dout_b}, 8'd0);
      oe_n = 1'b1;
      tick(2);
      check("rst_idx", {4'd0, idx_b}, 8'd0);
    end
    res_n = 1'b1;
    tick(6);
    check("rel_idx", {4'd0, idx_b}, 8'd0);
    check("rel_dout", {7'd0, dout_b}, 8'd0);

    // Full read of A+Start, then overrun into the fill bits.
    load(8'h09);
    for (int k = 0; k < 12; k++) do_read(k, 8'h09, 8'h09);

    // Debounce: 3-cycle glitch rejected, sustained press accepted with exact latency.
    btn    = 8'h00;
    strobe = 1'b1;
    tick(10);
    check("db_base", {7'd0, dout_b}, 8'd0);
    btn = 8'h01;
    tick(3);
    btn = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("db_glitch", {7'd0, dout_b}, 8'd0);
    end
    btn = 8'h01;
    tick(6);
    check("db_early", {7'd0, dout_b}, 8'd0);
    tick(2);
    check("db_accept", {7'd0, dout_b}, 8'd1);
    check("db_acc_nb", {7'd0, dout_nb}, 8'd1);
    strobe = 1'b0;
    tick(3);

    // Opposing directions, with and without blocking.
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'h30 : (t == 1) ? 8'hF0 : 8'hD1;
      load(b);
      for (int k = 0; k < 9; k++) do_read(k, model_mask(b, 1'b1), model_mask(b, 1'b0));
    end

    // OE_N held low across the strobe falling edge: only its later rise shifts.
    b      = 8'hA6;
    btn    = b;
    oe_n   = 1'b0;
    strobe = 1'b1;
    tick(10);
    strobe = 1'b0;
    tick(4);
    check("oe_span_idx0", {4'd0, idx_b}, 8'd0);
    oe_n = 1'b1;
    tick(3);
    check("oe_span_idx", {4'd0, idx_b}, 8'd1);
    check("oe_span_dout", {7'd0, dout_b}, model_bit(model_mask(b, 1'b1), 1));
    tick(1);

    // Random pads, random read counts, buttons sometimes changing mid-shift.
    for (int it = 0; it < 20; it++) begin
      b  = 8'($urandom);
      mb = model_mask(b, 1'b1);
      mn = model_mask(b, 1'b0);
      load(b);
      if ($urandom_range(0, 1) == 1) btn = 8'($urandom);
      n = $urandom_range(1, 11);
      for (int k = 0; k < n; k++) do_read(k, mb, mn);
    end

    // Read pulse while strobe is high is swallowed by the load.
    b  = 8'hF1;
    mb = model_mask(b, 1'b1);
    mn = model_mask(b, 1'b0);
    load(b);
    do_read(0, mb, mn);
    do_read(1, mb, mn);
    strobe = 1'b1;
    tick(3);
    oe_n = 1'b0;
    tick(2);
    oe_n = 1'b1;
    tick(4);
    check("coll_idx", {4'd0, idx_b}, 8'd0);
    check("coll_dout", {7'd0, dout_b}, {7'd0, mb[0]});
    check("coll_dout_nb", {7'd0, dout_nb}, {7'd0, mn[0]});
    strobe = 1'b0;
    tick(3);
    for (int k = 0; k < 3; k++) do_read(k, mb, mn);

    // Asynchronous abort mid-read, then reads return zeros until the next latch.
    res_n = 1'b0;
    #1;
    check("abort_idx", {4'd0, idx_b}, 8'd0);
    check("abort_dout", {7'd0, dout_b}, 8'd0);
    check("abort_dout_nb", {7'd0, dout_nb}, 8'd0);
    tick(2);
    res_n = 1'b1;
    tick(4);
    check("post_rst_idx", {4'd0, idx_b}, 8'd0);
    for (int k = 0; k < 3; k++) do_read(k, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
